// File: rtl/alu_serial_seq_if.sv
// Start/busy/done handshake bundle for the bit-serial ALU sequencer.
interface alu_serial_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       s;
  logic             arith;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             cout;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, s, arith,
    input  out, zero, cout, busy, done
  );

  modport slave (
    input  start, a, b, s, arith,
    output out, zero, cout, busy, done
  );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer driving a one-bit AND/OR/XOR/NOT cell, LSB first, WIDTH bits per op.
// Optional serial ADD (latched arith overrides s) is built only when ARITH_EN is defined.
module alu_serial_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  alu_serial_seq_if.slave   bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state,  w_state_nxt;
  logic [WIDTH-1:0] r_a_sr,   w_a_sr_nxt;
  logic [WIDTH-1:0] r_b_sr,   w_b_sr_nxt;
  logic [WIDTH-1:0] r_r_sr,   w_r_sr_nxt;
  logic [CW-1:0]    r_cnt,    w_cnt_nxt;
  logic [1:0]       r_s,      w_s_nxt;
  logic [WIDTH-1:0] r_out,    w_out_nxt;
  logic             r_zero,   w_zero_nxt;
  logic             r_busy,   w_busy_nxt;
  logic             r_done,   w_done_nxt;
  logic             w_bit;
  logic [WIDTH-1:0] w_result;
`ifdef ARITH_EN
  logic             r_arith,  w_arith_nxt;
  logic             r_carry,  w_carry_nxt;
  logic             r_cout,   w_cout_nxt;
  logic             w_carry_maj;
`endif

  // One-bit cell: logic op per latched s, or full-adder sum when arith is latched
  always_comb begin
    unique case (r_s)
      2'b00:   w_bit = r_a_sr[0] & r_b_sr[0];
      2'b01:   w_bit = r_a_sr[0] | r_b_sr[0];
      2'b10:   w_bit = r_a_sr[0] ^ r_b_sr[0];
      default: w_bit = ~r_a_sr[0];
    endcase
`ifdef ARITH_EN
    w_carry_maj = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_carry) | (r_b_sr[0] & r_carry);
    if (r_arith) w_bit = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
`endif
  end

  assign w_result = {w_bit, r_r_sr[WIDTH-1:1]};

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_a_sr_nxt  = r_a_sr;
    w_b_sr_nxt  = r_b_sr;
    w_r_sr_nxt  = r_r_sr;
    w_cnt_nxt   = r_cnt;
    w_s_nxt     = r_s;
    w_out_nxt   = r_out;
    w_zero_nxt  = r_zero;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
`ifdef ARITH_EN
    w_arith_nxt = r_arith;
    w_carry_nxt = r_carry;
    w_cout_nxt  = r_cout;
`endif

    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_a_sr_nxt  = bus.a;
          w_b_sr_nxt  = bus.b;
          w_s_nxt     = bus.s;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_RUN;
`ifdef ARITH_EN
          w_arith_nxt = bus.arith;
          w_carry_nxt = 1'b0;
`endif
        end
      end
      S_RUN: begin
        w_r_sr_nxt = w_result;
        w_a_sr_nxt = r_a_sr >> 1;
        w_b_sr_nxt = r_b_sr >> 1;
        w_cnt_nxt  = r_cnt + CW'(1);
`ifdef ARITH_EN
        w_carry_nxt = w_carry_maj;
`endif
        // Current bit is the MSB: publish the assembled word
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_out_nxt   = w_result;
          w_zero_nxt  = (w_result == '0);
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_DONE;
`ifdef ARITH_EN
          w_cout_nxt  = w_carry_maj;
`endif
        end
      end
      S_DONE: begin
        w_done_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_r_sr  <= '0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_out   <= '0;
      r_zero  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef ARITH_EN
      r_arith <= 1'b0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_a_sr  <= w_a_sr_nxt;
      r_b_sr  <= w_b_sr_nxt;
      r_r_sr  <= w_r_sr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_s     <= w_s_nxt;
      r_out   <= w_out_nxt;
      r_zero  <= w_zero_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
`ifdef ARITH_EN
      r_arith <= w_arith_nxt;
      r_carry <= w_carry_nxt;
      r_cout  <= w_cout_nxt;
`endif
    end
  end

  assign bus.out  = r_out;
  assign bus.zero = r_zero;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
`ifdef ARITH_EN
  assign bus.cout = r_cout;
`else
  assign bus.cout = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// Randomized self-checking bench for alu_serial_seq against a word-level reference model.
module tb_alu_serial_seq;

  localparam int unsigned W = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  logic [W-1:0] exp_out;
  logic         exp_zero;
  logic         exp_cout;

  alu_serial_seq_if #(.WIDTH(W)) bus ();

  alu_serial_seq #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Word-level reference: {carry, result}
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic [1:0] op, input logic ar);
`ifdef ARITH_EN
    if (ar) return {1'b0, x} + {1'b0, y};
`endif
    case (op)
      2'b00:   return {1'b0, x & y};
      2'b01:   return {1'b0, x | y};
      2'b10:   return {1'b0, x ^ y};
      default: return {1'b0, ~x};
    endcase
  endfunction

  task automatic set_expected(input logic [W:0] m);
    exp_out  = m[W-1:0];
    exp_zero = (m[W-1:0] == '0);
    exp_cout = m[W];
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".out"},  32'(bus.out),  32'(exp_out));
    check_eq({tag, ".zero"}, 32'(bus.zero), 32'(exp_zero));
    check_eq({tag, ".cout"}, 32'(bus.cout), 32'(exp_cout));
  endtask

  // One operation with a single-cycle start; operands are scrambled during RUN
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [1:0] ts, input logic tar);
    logic [W:0] m;
    int busy_cnt, done_at, done_cnt;
    logic hold_ok;
    m = model(ta, tb_v, ts, tar);
    @(negedge clk);
    bus.start = 1'b1; bus.a = ta; bus.b = tb_v; bus.s = ts; bus.arith = tar;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom);
    bus.s = 2'($urandom); bus.arith = 1'($urandom);
    busy_cnt = bus.busy ? 1 : 0;
    done_at = 0; done_cnt = 0; hold_ok = 1'b1;
    for (int k = 1; k <= int'(W) + 4; k++) begin
      @(posedge clk); #1;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end else if (done_at == 0 && bus.out !== exp_out) begin
        hold_ok = 1'b0;
      end
    end
    check_eq({tag, ".done_at"},  32'(done_at),  32'(W));
    check_eq({tag, ".done_cnt"}, 32'(done_cnt), 32'd1);
    check_eq({tag, ".busy_cnt"}, 32'(busy_cnt), 32'(W));
    check_eq({tag, ".hold"},     32'(hold_ok),  32'd1);
    set_expected(m);
    check_outputs(tag);
  endtask

  initial begin
    logic [W:0] m1, m2;
    int first_done, second_acc, done_seen;
    n_checks = 0; n_errors = 0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.s = '0; bus.arith = 1'b0;
    exp_out = '0; exp_zero = 1'b0; exp_cout = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs("reset");
    check_eq("reset.busy", 32'(bus.busy), 32'd0);
    check_eq("reset.done", 32'(bus.done), 32'd0);
    reset = 1'b0;

    // Directed logic ops
    run_op("and", 8'hA5, 8'h0F, 2'b00, 1'b0);
    run_op("or",  8'hA5, 8'h0F, 2'b01, 1'b0);
    run_op("xor", 8'hA5, 8'h0F, 2'b10, 1'b0);
    run_op("not", 8'hA5, 8'h0F, 2'b11, 1'b0);
    run_op("zero_and", 8'hF0, 8'h0F, 2'b00, 1'b0);
    run_op("zero_or",  8'hF0, 8'h0F, 2'b01, 1'b0);
    run_op("add", 8'hC8, 8'h64, 2'b10, 1'b1);

    // start held high: second accept at E(W+2), operands sampled then
    m1 = model(8'h3C, 8'h5A, 2'b01, 1'b0);
    m2 = model(8'h96, 8'h33, 2'b10, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h3C; bus.b = 8'h5A; bus.s = 2'b01; bus.arith = 1'b0;
    @(posedge clk); #1;
    bus.a = 8'h96; bus.b = 8'h33; bus.s = 2'b10;
    first_done = 0; second_acc = 0;
    for (int k = 1; k <= 3 * int'(W) && second_acc == 0; k++) begin
      @(posedge clk); #1;
      if (bus.done && first_done == 0) first_done = k;
      if (first_done != 0 && bus.busy) second_acc = k;
    end
    check_eq("b2b.first_done", 32'(first_done), 32'(W));
    check_eq("b2b.second_acc", 32'(second_acc), 32'(W + 2));
    set_expected(m1);
    check_outputs("b2b.op1");
    @(negedge clk);
    bus.start = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 2 * int'(W) && done_seen == 0; k++) begin
      @(posedge clk); #1;
      if (bus.done) done_seen = 1;
    end
    check_eq("b2b.done2", 32'(done_seen), 32'd1);
    set_expected(m2);
    check_outputs("b2b.op2");

    // Asynchronous reset in the 4th RUN cycle
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h77; bus.b = 8'h11; bus.s = 2'b01;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    exp_out = '0; exp_zero = 1'b0; exp_cout = 1'b0;
    check_outputs("rst_mid");
    check_eq("rst_mid.busy", 32'(bus.busy), 32'd0);
    check_eq("rst_mid.done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 2 * int'(W); k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) done_seen = 1;
    end
    check_eq("rst_mid.quiet", 32'(done_seen), 32'd0);
    run_op("post_rst", 8'h77, 8'h11, 2'b01, 1'b0);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      run_op($sformatf("rnd%0d", i), W'($urandom), W'($urandom), 2'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
